// File: rtl/sar_search.sv
// sar_search: successive-approximation search that recovers the comparator's B
// operand by driving trial values on A, one bit per clock, MSB first.
// Ports: clk_i/rst_n_i (async active-low), start_i, trial_o -> comparator A,
//        A_lez_B_i/A_grt_B_i/A_eql_B_i flags in, busy_o, done_o (1-cycle pulse),
//        result_o, early_o, err_o (all three held until the next accepted start).
module sar_search #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  output logic [WIDTH-1:0] trial_o,
  input  logic             A_lez_B_i,
  input  logic             A_grt_B_i,
  input  logic             A_eql_B_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             early_o,
  output logic             err_o
);

  localparam int            KW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [KW-1:0] K_TOP = KW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TEST = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             early_q, early_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] trial_test;
  logic [WIDTH-1:0] acc_next;
  logic [2:0]       flags;
  logic             flags_onehot;

  // Candidate: bits already decided plus the bit under test.
  assign trial_test   = acc_q | (WIDTH'(1) << k_q);
  assign flags        = {A_lez_B_i, A_grt_B_i, A_eql_B_i};
  assign flags_onehot = (flags == 3'b100) || (flags == 3'b010) || (flags == 3'b001);
  // Keep the tested bit only when the trial is still below B.
  assign acc_next     = A_lez_B_i ? trial_test : acc_q;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    k_d      = k_q;
    result_d = result_q;
    early_d  = early_q;
    err_d    = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_TEST;
          acc_d   = '0;
          k_d     = K_TOP;
          early_d = 1'b0;
          err_d   = 1'b0;
        end
      end
      S_TEST: begin
        if (!flags_onehot) begin
          err_d    = 1'b1;
          result_d = acc_q;
          state_d  = S_DONE;
        end else if (A_eql_B_i) begin
          acc_d    = trial_test;
          result_d = trial_test;
          early_d  = (k_q != '0);
          state_d  = S_DONE;
        end else begin
          acc_d = acc_next;
          if (k_q == '0) begin
            result_d = acc_next;
            state_d  = S_DONE;
          end else begin
            k_d = k_q - KW'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      k_q      <= K_TOP;
      result_q <= '0;
      early_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      k_q      <= k_d;
      result_q <= result_d;
      early_q  <= early_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    trial_o = '0;
    unique case (state_q)
      S_TEST:  trial_o = trial_test;
      S_DONE:  trial_o = result_q;
      default: trial_o = '0;
    endcase
  end

  assign busy_o   = (state_q == S_TEST);
  assign done_o   = (state_q == S_DONE);
  assign result_o = result_q;
  assign early_o  = early_q;
  assign err_o    = err_q;

endmodule

// File: tb/tb_sar_search.sv
module tb_sar_search;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] trial;
  logic         lez, grt, eql;
  logic         busy, done, early, err;
  logic [W-1:0] result;

  int           B = 0;
  logic         force_en = 1'b0;
  logic [2:0]   force_flags = 3'b000;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Combinational magnitude comparator, with an override for fault injection.
  always_comb begin
    if (force_en) begin
      {lez, grt, eql} = force_flags;
    end else begin
      lez = (int'(trial) <  B);
      grt = (int'(trial) >  B);
      eql = (int'(trial) == B);
    end
  end

  sar_search #(.WIDTH(W)) dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .start_i   (start),
    .trial_o   (trial),
    .A_lez_B_i (lez),
    .A_grt_B_i (grt),
    .A_eql_B_i (eql),
    .busy_o    (busy),
    .done_o    (done),
    .result_o  (result),
    .early_o   (early),
    .err_o     (err)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One full search against the reference: the trial at bit k is B with all
  // bits below k cleared and bit k set; the search stops at B's lowest set bit.
  task automatic run_search(input int b, input int err_step, input logic [2:0] ef,
                            input bit hold, input bit repulse);
    int ctz, n, kk, t, steps, exp_res, exp_early, exp_err;
    ctz = 0;
    if (b != 0) while (((b >> ctz) & 1) == 0) ctz++;
    n         = (b == 0) ? W : W - ctz;
    exp_res   = b;
    exp_early = (b != 0 && ctz != 0) ? 1 : 0;
    exp_err   = 0;
    if (err_step >= 0 && err_step < n) begin
      n         = err_step + 1;
      kk        = W - 1 - err_step;
      exp_res   = (b >> (kk + 1)) << (kk + 1);
      exp_early = 0;
      exp_err   = 1;
    end
    @(negedge clk);
    B     = b;
    start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    steps = 0;
    while (busy === 1'b1 && steps < W + 1) begin
      kk = W - 1 - steps;
      t  = ((b >> kk) << kk) | (1 << kk);
      check("trial", int'(trial), t);
      if (steps == err_step) begin
        force_en    = 1'b1;
        force_flags = ef;
      end
      if (repulse && steps == 1) start = 1'b1;
      @(posedge clk); #1;
      force_en = 1'b0;
      if (repulse) start = 1'b0;
      steps++;
    end
    check("busy_cycles", steps, n);
    check("done_pulse", int'(done), 1);
    check("result", int'(result), exp_res);
    check("early", int'(early), exp_early);
    check("err", int'(err), exp_err);
    check("trial_in_done", int'(trial), exp_res);
    @(posedge clk); #1;
    check("done_cleared", int'(done), 0);
    check("idle_busy", int'(busy), 0);
    check("idle_trial", int'(trial), 0);
    check("result_held", int'(result), exp_res);
    check("err_held", int'(err), exp_err);
  endtask

  initial begin
    logic [2:0] bad_flags [5];
    int b, e;
    bad_flags[0] = 3'b000; bad_flags[1] = 3'b011; bad_flags[2] = 3'b101;
    bad_flags[3] = 3'b110; bad_flags[4] = 3'b111;

    // Reset state.
    #1;
    check("rst_trial", int'(trial), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_result", int'(result), 0);
    check("rst_early", int'(early), 0);
    check("rst_err", int'(err), 0);
    @(negedge clk); rst_n = 1'b1;

    // Directed searches.
    run_search(11, -1, 3'b000, 1'b0, 1'b0);
    run_search(8,  -1, 3'b000, 1'b0, 1'b0);
    run_search(0,  -1, 3'b000, 1'b0, 1'b0);
    run_search(15, -1, 3'b000, 1'b0, 1'b0);
    // Illegal flags on the second TEST cycle.
    run_search(11, 1, 3'b000, 1'b0, 1'b0);
    run_search(11, 1, 3'b110, 1'b0, 1'b0);
    // Start re-pulsed mid-search must be ignored.
    run_search(6, -1, 3'b000, 1'b0, 1'b1);
    @(posedge clk); #1;
    check("no_requeue_busy", int'(busy), 0);
    // Start held high: back-to-back searches with one IDLE cycle between.
    run_search(11, -1, 3'b000, 1'b1, 1'b0);
    run_search(3,  -1, 3'b000, 1'b1, 1'b0);
    run_search(9,  -1, 3'b000, 1'b0, 1'b0);

    // Reset during the third TEST cycle aborts without done.
    @(negedge clk); B = 11; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_abort_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("abort_trial", int'(trial), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_result", int'(result), 0);
    check("abort_early", int'(early), 0);
    check("abort_err", int'(err), 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_abort_done", int'(done), 0);
    check("post_abort_busy", int'(busy), 0);
    run_search(5, -1, 3'b000, 1'b0, 1'b0);

    // Randomized searches, some with injected illegal flags.
    for (int i = 0; i < 24; i++) begin
      b = int'($urandom_range(0, (1 << W) - 1));
      if (i % 3 == 2) begin
        e = int'($urandom_range(0, W - 1));
        run_search(b, e, bad_flags[$urandom_range(0, 4)], 1'b0, 1'b0);
      end else begin
        run_search(b, -1, 3'b000, 1'b0, 1'b0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
